// File: rtl/mem_stage_pkg.sv
// Shared definitions for the data-memory stage: opcode constants, access
// size codes (funct3[1:0]), FSM state encoding and an alignment helper.
package mem_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3[1:0] size codes; funct3[2] is the unsigned flag, handled by execute
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Natural alignment: byte anywhere, half on even, word on multiple of 4.
  // Size code 3 is treated as a word.
  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane logic for the memory stage.
//   size, offset : access size code and byte offset inside the word
//   st_data      : store source (rs2)      -> be, wdata (lane-replicated)
//   ld_word      : raw bus read word       -> ld_aligned (MSB-justified)
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_aligned
);

  logic [31:0] shifted;

  always_comb begin
    // bring the addressed byte/half down to bit 0, then justify to the top
    shifted    = ld_word >> {offset, 3'b000};
    be         = 4'hF;
    wdata      = st_data;
    ld_aligned = ld_word;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << offset;
        wdata      = {4{st_data[7:0]}};
        ld_aligned = {shifted[7:0], 24'h0};
      end
      SZ_HALF: begin
        be         = 4'b0011 << offset;
        wdata      = {2{st_data[15:0]}};
        ld_aligned = {shifted[15:0], 16'h0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Data-memory stage: serves loads/stores from execute over a valid/ready bus,
// realigns load data, drives the writeback pair and stalls while a bus access
// is outstanding.
//   in_valid/operation/exec_out/content_rs2/address_rd : from execute
//   bus_*      : data bus master (fields held stable while bus_valid)
//   mem_data   : MSB-justified load word to execute
//   forward/fwd_rd : writeback value / register (0 = none)
//   stall      : high while a transaction is outstanding
//   misalign, bus_err : one-cycle error pulses
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [11:0]     operation,
  input  logic [XLEN-1:0] exec_out,
  input  logic [XLEN-1:0] content_rs2,
  input  logic [4:0]      address_rd,
  output logic            bus_valid,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [31:0]     bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_ready,
  input  logic [31:0]     bus_rdata,
  output logic [31:0]     mem_data,
  output logic            stall,
  output logic [XLEN-1:0] forward,
  output logic [4:0]      fwd_rd,
  output logic            misalign,
  output logic            bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bus_valid_q, bus_valid_d, bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [31:0]     mem_data_q, mem_data_d;
  logic [XLEN-1:0] forward_q, forward_d;
  logic [4:0]      fwd_rd_q, fwd_rd_d, ld_rd_q, ld_rd_d;
  logic            misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [1:0]      ld_size_q, ld_size_d, ld_off_q, ld_off_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store;
  logic [1:0]  size_sel, off_sel;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld;
  logic        unused_bits;

  assign opcode      = operation[6:0];
  assign funct3      = operation[9:7];
  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_STORE);
  assign unused_bits = ^{operation[11:10], funct3[2]};

  // The lane unit serves the incoming store in IDLE and the pending load's
  // realignment in WAIT, so one instance covers both.
  assign size_sel = (state_q == ST_WAIT) ? ld_size_q : funct3[1:0];
  assign off_sel  = (state_q == ST_WAIT) ? ld_off_q  : exec_out[1:0];

  mem_align u_align (
    .size       (size_sel),
    .offset     (off_sel),
    .st_data    (content_rs2[31:0]),
    .ld_word    (bus_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .ld_aligned (al_ld)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    mem_data_d  = mem_data_q;
    forward_d   = forward_q;
    ld_rd_d     = ld_rd_q;
    ld_size_d   = ld_size_q;
    ld_off_d    = ld_off_q;
    fwd_rd_d    = 5'd0;   // writeback is a one-cycle event
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_load || is_store) begin
            if (is_aligned(funct3[1:0], exec_out[1:0])) begin
              bus_valid_d = 1'b1;
              bus_we_d    = is_store;
              bus_addr_d  = {exec_out[XLEN-1:2], 2'b00};
              bus_be_d    = al_be;
              bus_wdata_d = is_store ? al_wdata : 32'h0;
              ld_rd_d     = address_rd;
              ld_size_d   = funct3[1:0];
              ld_off_d    = exec_out[1:0];
              cnt_d       = '0;
              state_d     = ST_WAIT;
            end else begin
              misalign_d = 1'b1;
            end
          end else begin
            forward_d = exec_out;
            fwd_rd_d  = address_rd;
          end
        end
      end
      ST_WAIT: begin
        // ready takes priority over an expiring timeout
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (!bus_we_q) begin
            mem_data_d = al_ld;
            forward_d  = XLEN'(al_ld);
            fwd_rd_d   = ld_rd_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d   = 1'b1;
          bus_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      mem_data_q  <= '0;
      forward_q   <= '0;
      fwd_rd_q    <= '0;
      ld_rd_q     <= '0;
      ld_size_q   <= '0;
      ld_off_q    <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      mem_data_q  <= mem_data_d;
      forward_q   <= forward_d;
      fwd_rd_q    <= fwd_rd_d;
      ld_rd_q     <= ld_rd_d;
      ld_size_q   <= ld_size_d;
      ld_off_q    <= ld_off_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign stall     = (state_q == ST_WAIT);
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign mem_data  = mem_data_q;
  assign forward   = forward_q;
  assign fwd_rd    = fwd_rd_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-lane model.
module tb_mem_stage;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ALU = 7'b0110011;

  logic            clk = 1'b0, reset;
  logic            in_valid;
  logic [11:0]     operation;
  logic [XLEN-1:0] exec_out, content_rs2;
  logic [4:0]      address_rd;
  logic            bus_valid, bus_we, bus_ready;
  logic [XLEN-1:0] bus_addr;
  logic [31:0]     bus_wdata, bus_rdata, mem_data;
  logic [3:0]      bus_be;
  logic            stall, misalign, bus_err;
  logic [XLEN-1:0] forward;
  logic [4:0]      fwd_rd;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .operation(operation),
    .exec_out(exec_out), .content_rs2(content_rs2), .address_rd(address_rd),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .mem_data(mem_data), .stall(stall),
    .forward(forward), .fwd_rd(fwd_rd), .misalign(misalign), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model: byte-lane arithmetic ----
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input int o);
    logic [3:0] b = '0;
    for (int i = 0; i < 4; i++) b[i] = (i >= o) && (i < o + nbytes(sz));
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] rs2);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input int o, input logic [31:0] rd);
    logic [31:0] r = '0;
    int n = nbytes(sz);
    for (int j = 0; j < n; j++) r[8*(4-n+j) +: 8] = rd[8*(o+j) +: 8];
    return r;
  endfunction

  // Present one instruction, act as the slave with `waits` not-ready cycles
  // (waits >= TIMEOUT means the slave never answers), and check every step.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input int waits,
                        input logic [31:0] rdata);
    bit is_ld = (opc == LD);
    bit is_st = (opc == ST);
    int o = int'(addr[1:0]);
    bit ok = (o % nbytes(f3[1:0])) == 0;
    in_valid = 1'b1; operation = {2'b00, f3, opc}; exec_out = addr;
    content_rs2 = rs2; address_rd = rd; bus_ready = 1'b0;
    @(negedge clk);
    // garbage from execute; must be ignored while stalled
    in_valid = 1'($urandom_range(0, 1)); operation = {5'd0, ALU};
    address_rd = 5'd9; exec_out = $urandom();
    if (!is_ld && !is_st) begin
      chk("alu_forward", forward, addr);
      chk("alu_fwd_rd", fwd_rd, rd);
      chk("alu_stall", stall, 0);
      chk("alu_bus_valid", bus_valid, 0);
    end else if (!ok) begin
      chk("mis_pulse", misalign, 1);
      chk("mis_bus_valid", bus_valid, 0);
      chk("mis_stall", stall, 0);
      chk("mis_fwd_rd", fwd_rd, 0);
    end else begin
      chk("iss_bus_valid", bus_valid, 1);
      chk("iss_stall", stall, 1);
      chk("iss_we", bus_we, is_st);
      chk("iss_addr", bus_addr, {addr[31:2], 2'b00});
      if (is_st) begin
        chk("st_be", bus_be, m_be(f3[1:0], o));
        chk("st_wdata", bus_wdata, m_wdata(f3[1:0], rs2));
      end
      if (waits >= TIMEOUT) begin
        for (int k = 1; k < TIMEOUT; k++) begin
          @(negedge clk);
          chk("to_stall", stall, 1);
          chk("to_no_err", bus_err, 0);
        end
        @(negedge clk);
        chk("to_bus_err", bus_err, 1);
        chk("to_stall_drop", stall, 0);
        chk("to_bus_valid", bus_valid, 0);
        chk("to_fwd_rd", fwd_rd, 0);
      end else begin
        for (int k = 0; k < waits; k++) begin
          @(negedge clk);
          chk("wait_stall", stall, 1);
          chk("wait_bus_valid", bus_valid, 1);
        end
        bus_ready = 1'b1; bus_rdata = rdata;
        @(negedge clk);
        bus_ready = 1'b0; bus_rdata = $urandom();
        chk("done_stall", stall, 0);
        chk("done_bus_valid", bus_valid, 0);
        chk("done_no_err", bus_err, 0);
        if (is_ld) begin
          chk("ld_mem_data", mem_data, m_load(f3[1:0], o, rdata));
          chk("ld_forward", forward, m_load(f3[1:0], o, rdata));
          chk("ld_fwd_rd", fwd_rd, rd);
        end else begin
          chk("st_fwd_rd", fwd_rd, 0);
        end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_pulses", {stall, misalign, bus_err}, 3'b000);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; operation = '0; exec_out = '0;
    content_rs2 = '0; address_rd = '0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {bus_valid, bus_we, bus_addr, bus_wdata, bus_be}, '0);
    chk("rst_wb", {mem_data, stall, fwd_rd, misalign, bus_err}, '0);
    chk("rst_forward", forward, 0);
    reset = 1'b0;
    @(negedge clk);

    // directed scenarios
    run_op(ST,  3'b010, 32'h100, 32'hDEADBEEF, 5'd3, 0, 32'h0);
    run_op(LD,  3'b000, 32'h103, 32'h0,        5'd5, 1, 32'h80112233);
    run_op(ST,  3'b001, 32'h102, 32'h0000ABCD, 5'd2, 2, 32'h0);
    run_op(LD,  3'b001, 32'h101, 32'h0,        5'd6, 0, 32'h0);
    run_op(LD,  3'b010, 32'h200, 32'h0,        5'd8, TIMEOUT, 32'h0);
    run_op(LD,  3'b010, 32'h204, 32'h0,        5'd8, TIMEOUT-1, 32'h12345678);
    run_op(ALU, 3'b000, 32'h55,  32'h0,        5'd7, 0, 32'h0);
    run_op(LD,  3'b100, 32'h302, 32'h0,        5'd0, 0, 32'hCAFEF00D);

    // asynchronous reset in the middle of a wait
    in_valid = 1'b1; operation = {2'b00, 3'b010, LD}; exec_out = 32'h400; address_rd = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw_stall", stall, 1);
    #2 reset = 1'b1;
    #1;
    chk("rw_async_bus", {bus_valid, bus_we, bus_addr, bus_be, bus_wdata}, '0);
    chk("rw_async_wb", {stall, fwd_rd, mem_data, misalign, bus_err}, '0);
    chk("rw_async_fwd", forward, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(LD, 3'b010, 32'h404, 32'h0, 5'd4, 0, 32'hA5A5_5A5A);

    // randomized mix
    for (int t = 0; t < 80; t++) begin
      logic [6:0] opc;
      int kind = $urandom_range(0, 2);
      int w = $urandom_range(0, 3);
      opc = (kind == 0) ? ALU : (kind == 1) ? LD : ST;
      if ($urandom_range(0, 15) == 0) w = TIMEOUT - 1 + $urandom_range(0, 1);
      run_op(opc, 3'($urandom_range(0, 2)) | {1'($urandom_range(0, 1)), 2'b00},
             $urandom(), $urandom(), 5'($urandom()), w, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
